logic_gate_pipe: RTL and testbench
==================================

// Module: logic_gate_pipe
// PURPOSE
//  Parametrised, pipelined successor to the single-bit two-input gate.
//  - Applies one of eight bitwise logic ops to two WIDTH-bit operands.
//  - Carries the result through STAGES registered stages under valid/ready flow control.
//  - Flags all-ones and any-one results.
//  - Reusable datapath primitive; the tutorial gate benches run against it.
// PARAMETERS
//  WIDTH   8  operand/result width in bits, >=1
//  STAGES  2  number of pipeline register stages, >=1 (= latency with no stall)
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      a, b, op valid this cycle
//  in_ready   out  1      block accepts a, b, op this cycle
//  op         in   3      operation select (encoding below)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  out_valid  out  1      y, y_all, y_any valid
//  out_ready  in   1      consumer accepts result this cycle
//  y          out  WIDTH  result
//  y_all      out  1      &y (result is all ones)
//  y_any      out  1      |y (result nonzero)
//  popcnt     out  $clog2(WIDTH+1)  ones in y; only with LOGIC_GATE_POPCNT_EN
// BEHAVIOUR
//  - op encoding:
//    - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
//    - 6 ANDN (a & ~b), 7 PASS (y = a).
//  - Result is computed combinationally from a, b, op and captured into stage 0 on accept.
//  - Accept = in_valid & in_ready.
//  - y_all, y_any (and popcnt) are computed before stage 0 and travel with the data.
//    They are never recomputed from the output register.
//  - Stages 0..STAGES-1 each hold {v[i], data[i]}:
//    - Stage i loads when ld[i] = ~v[i] | ld[i+1].
//    - The last stage loads when ld[STAGES-1] = ~v[STAGES-1] | out_ready.
//    - in_ready = ld[0]. It is combinational from out_ready (bubble-collapsing, no skid).
//  - Outputs: out_valid = v[STAGES-1]; y/y_all/y_any = data[STAGES-1].
//  - Timing and ordering:
//    - Latency is exactly STAGES cycles from accept to out_valid when out_ready is held 1.
//    - Throughput is 1 result/cycle.
//    - Results emerge in accept order. Nothing is dropped or duplicated.
//  - Handshake rules:
//    - Output is stable while out_valid & ~out_ready: y, y_all, y_any, popcnt do not change.
//    - Input arriving with in_valid=1 and in_ready=0 is not consumed.
//      The source holds it until accepted.
//  - Full/stall: all v=1 with out_ready=0 gives in_ready=0 in the same cycle.
//    - out_ready=1 in that state gives in_ready=1: simultaneous pop and push, occupancy unchanged.
//  - Empty: all v=0 gives in_ready=1 regardless of out_ready, and out_valid=0.
//  - Reset:
//    - rst=1 clears every v[i] and data[i] to 0 at the next edge.
//    - This applies mid-transfer too; in-flight results are discarded.
//    - After reset: out_valid=0, y=0, y_all=0, y_any=0, popcnt=0.
//    - in_ready=1 from the first cycle after rst drops.
//    - While rst=1: in_ready=0. Inputs are ignored.
//  - Width rules:
//    - y_all for WIDTH=1 equals y. popcnt range is 0..WIDTH.
//    - No arithmetic carries; ops are purely bitwise.
// CONFIGURATION
//  - LOGIC_GATE_POPCNT_EN defined:
//    - popcnt port exists. It is carried through the pipeline and reset to 0.
//  - LOGIC_GATE_POPCNT_EN undefined:
//    - popcnt port and its pipeline bits are absent.
//    - All other behaviour is identical.
// TESTING  (WIDTH=8, STAGES=2)
//  1. Reset:
//     - rst=1 for 2 cycles with in_valid=1 -> out_valid=0, y=0, in_ready=0.
//     - After release -> in_ready=1.
//  2. All ops, out_ready=1, a=8'hC5, b=8'h0F, op=0..7 back-to-back
//     -> y = 05, CF, CA, FA, 30, 35, C0, C5. Each appears 2 cycles after accept.
//  3. Flags:
//     - a=FF, b=FF, op=AND -> y_all=1, y_any=1 (popcnt=8 if enabled).
//     - a=00, b=00, op=OR -> y_all=0, y_any=0.
//  4. Backpressure:
//     - Send 3 items with out_ready=0 -> in_ready=0 after 2 accepts.
//     - out_valid holds item 1 stable.
//     - Raise out_ready -> items 1, 2, 3 emerge in order, none lost.
//  5. Simultaneous push/pop when full -> accepted the same cycle.
//     - Continuous stream of 10 items -> 10 outputs in 10 consecutive cycles.
//  6. Mid-operation reset:
//     - rst=1 with 2 items in flight -> out_valid=0 the next cycle.
//     - Neither item ever appears at the output.

Source files
------------

// File: rtl/logic_gate_pipe_if.sv
// Valid/ready bus of logic_gate_pipe. The popcnt signal exists only when
// LOGIC_GATE_POPCNT_EN is defined.
interface logic_gate_pipe_if #(
  parameter int WIDTH = 8
);
`ifdef LOGIC_GATE_POPCNT_EN
  localparam int PW = $clog2(WIDTH + 1);
  logic [PW-1:0]    popcnt;
`endif
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_all;
  logic             y_any;

  modport master (
    output in_valid, op, a, b, out_ready,
`ifdef LOGIC_GATE_POPCNT_EN
    input  popcnt,
`endif
    input  in_ready, out_valid, y, y_all, y_any
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
`ifdef LOGIC_GATE_POPCNT_EN
    output popcnt,
`endif
    output in_ready, out_valid, y, y_all, y_any
  );
endinterface

// File: rtl/logic_gate_pipe.sv
// Bitwise 8-op logic gate followed by a STAGES-deep bubble-collapsing valid/ready pipeline.
// The optional popcnt output is enabled by LOGIC_GATE_POPCNT_EN.
module logic_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  logic_gate_pipe_if.slave bus
);
`ifdef LOGIC_GATE_POPCNT_EN
  localparam int PW = $clog2(WIDTH + 1);
  localparam int DW = WIDTH + 2 + PW;
`else
  localparam int DW = WIDTH + 2;
`endif

  function automatic logic [WIDTH-1:0] gate_op(input logic [2:0]       op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    gate_op = a & b;
      3'd1:    gate_op = a | b;
      3'd2:    gate_op = a ^ b;
      3'd3:    gate_op = ~(a & b);
      3'd4:    gate_op = ~(a | b);
      3'd5:    gate_op = ~(a ^ b);
      3'd6:    gate_op = a & ~b;
      default: gate_op = a;
    endcase
  endfunction

`ifdef LOGIC_GATE_POPCNT_EN
  function automatic logic [PW-1:0] count_ones(input logic [WIDTH-1:0] v);
    count_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_ones = count_ones + PW'(v[i]);
    end
  endfunction
`endif

  logic [WIDTH-1:0]  res_s;
  logic [DW-1:0]     word_s;
  logic              accept_s;
  logic [STAGES-1:0] ld_s;
  logic [STAGES-1:0] src_v_s;
  logic [DW-1:0]     src_d_s [STAGES];
  logic [STAGES-1:0] v_q;
  logic [DW-1:0]     data_q  [STAGES];

  // Result word {popcnt, y_any, y_all, y}; flags are computed here, not at the output.
  always_comb begin
    res_s = gate_op(bus.op, bus.a, bus.b);
`ifdef LOGIC_GATE_POPCNT_EN
    word_s = {count_ones(res_s), |res_s, &res_s, res_s};
`else
    word_s = {|res_s, &res_s, res_s};
`endif
  end

  // Stage i may load when it or any later stage has a hole, or when the consumer pops.
  always_comb begin
    logic chain_s;
    chain_s = bus.out_ready;
    ld_s    = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      chain_s = chain_s | ~v_q[i];
      ld_s[i] = chain_s;
    end
  end

  assign bus.in_ready = ld_s[0] & ~rst;
  assign accept_s     = bus.in_valid & bus.in_ready;

  // Source of each stage: the new word for stage 0, the previous stage otherwise.
  always_comb begin
    src_v_s    = '0;
    for (int i = 0; i < STAGES; i++) begin
      src_d_s[i] = '0;
    end
    src_v_s[0] = accept_s;
    src_d_s[0] = word_s;
    for (int i = 1; i < STAGES; i++) begin
      src_v_s[i] = v_q[i-1];
      src_d_s[i] = data_q[i-1];
    end
  end

  // Pipeline registers; data only moves when a valid word arrives, so a drained stage keeps its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (ld_s[i]) begin
          v_q[i] <= src_v_s[i];
          if (src_v_s[i]) begin
            data_q[i] <= src_d_s[i];
          end
        end
      end
    end
  end

  assign bus.out_valid = v_q[STAGES-1];
  assign bus.y         = data_q[STAGES-1][WIDTH-1:0];
  assign bus.y_all     = data_q[STAGES-1][WIDTH];
  assign bus.y_any     = data_q[STAGES-1][WIDTH+1];
`ifdef LOGIC_GATE_POPCNT_EN
  assign bus.popcnt    = data_q[STAGES-1][DW-1:WIDTH+2];
`endif
endmodule

// File: tb/tb_logic_gate_pipe.sv
// Self-checking bench for logic_gate_pipe (WIDTH=8, STAGES=2): vector table,
// hand-written flow-control sequences and a randomized run against a queue model.
module tb_logic_gate_pipe;
  localparam int W = 8;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_gate_pipe_if #(.WIDTH(W)) bus ();
  logic_gate_pipe #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [W-1:0] y;
    logic         all;
    logic         any;
    int           pc;
  } res_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         all;
    logic         any;
    int           pc;
  } vec_t;

  int   tests   = 0;
  int   failed  = 0;
  int   pushes  = 0;
  int   pops    = 0;
  int   dropped = 0;
  res_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Each op as a 4-entry truth table indexed by {a_bit, b_bit}.
  function automatic res_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [3:0] tt [8];
    res_t r;
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
    tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0100; tt[7] = 4'b1100;
    for (int i = 0; i < W; i++) r.y[i] = tt[op][{a[i], b[i]}];
    r.all = (r.y == {W{1'b1}});
    r.any = (r.y != '0);
    r.pc  = $countones(r.y);
    return r;
  endfunction

  task automatic win();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: order/value of every output, in_ready rule and stall stability.
  initial begin
    res_t         r;
    logic         stall;
    logic [W-1:0] st_y;
    logic         st_all, st_any;
    stall = 1'b0;
    st_y = '0; st_all = 1'b0; st_any = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        dropped += exp_q.size();
        exp_q.delete();
        stall = 1'b0;
      end else begin
        check("in_ready_rule", 32'(bus.in_ready), 32'((exp_q.size() < S) || bus.out_ready));
        if (stall) begin
          check("stall_valid", 32'(bus.out_valid), 32'd1);
          check("stall_y", 32'(bus.y), 32'(st_y));
          check("stall_flags", 32'({bus.y_all, bus.y_any}), 32'({st_all, st_any}));
        end
        if (bus.out_valid && bus.out_ready) begin
          check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            pops++;
            check("out_y", 32'(bus.y), 32'(r.y));
            check("out_all", 32'(bus.y_all), 32'(r.all));
            check("out_any", 32'(bus.y_any), 32'(r.any));
`ifdef LOGIC_GATE_POPCNT_EN
            check("out_popcnt", 32'(bus.popcnt), 32'(r.pc));
`endif
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(model(bus.op, bus.a, bus.b));
          pushes++;
        end
        stall  = bus.out_valid && !bus.out_ready;
        st_y   = bus.y;
        st_all = bus.y_all;
        st_any = bus.y_any;
      end
    end
  end

  initial begin
    vec_t vecs [10];
    vec_t bp [3];
    int   sent;
    int   p0;
    logic hold;

    vecs[0] = '{3'd0, 8'hC5, 8'h0F, 8'h05, 1'b0, 1'b1, 2};
    vecs[1] = '{3'd1, 8'hC5, 8'h0F, 8'hCF, 1'b0, 1'b1, 6};
    vecs[2] = '{3'd2, 8'hC5, 8'h0F, 8'hCA, 1'b0, 1'b1, 4};
    vecs[3] = '{3'd3, 8'hC5, 8'h0F, 8'hFA, 1'b0, 1'b1, 6};
    vecs[4] = '{3'd4, 8'hC5, 8'h0F, 8'h30, 1'b0, 1'b1, 2};
    vecs[5] = '{3'd5, 8'hC5, 8'h0F, 8'h35, 1'b0, 1'b1, 4};
    vecs[6] = '{3'd6, 8'hC5, 8'h0F, 8'hC0, 1'b0, 1'b1, 2};
    vecs[7] = '{3'd7, 8'hC5, 8'h0F, 8'hC5, 1'b0, 1'b1, 4};
    vecs[8] = '{3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 8};
    vecs[9] = '{3'd1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0};
    bp[0]   = '{3'd2, 8'h12, 8'h34, 8'h26, 1'b0, 1'b1, 3};
    bp[1]   = '{3'd1, 8'h0F, 8'hF0, 8'hFF, 1'b1, 1'b1, 8};
    bp[2]   = '{3'd3, 8'hAA, 8'hAA, 8'h55, 1'b0, 1'b1, 4};

    rst = 1'b1;
    bus.in_valid = 1'b1; bus.op = 3'd1; bus.a = 8'hA5; bus.b = 8'h5A; bus.out_ready = 1'b1;

    // Reset held with in_valid=1
    for (int k = 0; k < 2; k++) begin
      win(); #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_y", 32'(bus.y), 32'd0);
      check("rst_ready", 32'(bus.in_ready), 32'd0);
    end
    win();
    rst = 1'b0; bus.in_valid = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_out", 32'({bus.out_valid, bus.y, bus.y_all, bus.y_any}), 32'd0);
`ifdef LOGIC_GATE_POPCNT_EN
    check("post_rst_popcnt", 32'(bus.popcnt), 32'd0);
`endif

    // Table: all ops and flag corners, back-to-back, each result exactly 2 cycles later
    for (int k = 0; k < 12; k++) begin
      win();
      if (k < 10) begin
        bus.in_valid = 1'b1; bus.op = vecs[k].op; bus.a = vecs[k].a; bus.b = vecs[k].b;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      check("tbl_in_ready", 32'(bus.in_ready), 32'd1);
      if (k >= 2) begin
        check("tbl_valid", 32'(bus.out_valid), 32'd1);
        check("tbl_y", 32'(bus.y), 32'(vecs[k-2].y));
        check("tbl_flags", 32'({bus.y_all, bus.y_any}), 32'({vecs[k-2].all, vecs[k-2].any}));
`ifdef LOGIC_GATE_POPCNT_EN
        check("tbl_popcnt", 32'(bus.popcnt), 32'(vecs[k-2].pc));
`endif
      end
    end
    win(); #1;
    check("tbl_drained", 32'(bus.out_valid), 32'd0);

    // Backpressure: fill with out_ready=0, third item held off
    p0 = pops;
    sent = 0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      win();
      bus.in_valid = 1'b1; bus.op = bp[sent].op; bus.a = bp[sent].a; bus.b = bp[sent].b;
      #1;
      if (sent == 2) begin
        check("bp_full_ready", 32'(bus.in_ready), 32'd0);
        check("bp_head_valid", 32'(bus.out_valid), 32'd1);
        check("bp_head_y", 32'(bus.y), 32'(bp[0].y));
      end
      if (bus.in_ready) sent++;
    end
    check("bp_sent", 32'(sent), 32'd2);
    win();
    bus.out_ready = 1'b1;
    #1;
    check("full_pushpop_ready", 32'(bus.in_ready), 32'd1);
    win();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0 && !bus.out_valid) break;
      win();
    end
    check("bp_drain_empty", 32'(exp_q.size()), 32'd0);
    check("bp_count", 32'(pops - p0), 32'd3);

    // Continuous stream of 10 items with out_ready=1
    p0 = pops;
    for (int k = 0; k < 12; k++) begin
      win();
      if (k < 10) begin
        bus.in_valid = 1'b1; bus.op = 3'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      check("stream_ready", 32'(bus.in_ready), 32'd1);
      if (k >= 2) check("stream_valid", 32'(bus.out_valid), 32'd1);
    end
    win(); #1;
    check("stream_count", 32'(pops - p0), 32'd10);

    // Mid-operation reset with two items in flight
    p0 = pops;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      win();
      bus.in_valid = 1'b1; bus.op = 3'd7; bus.a = 8'h3C + 8'(k); bus.b = 8'h00;
    end
    win();
    bus.in_valid = 1'b0; rst = 1'b1;
    win();
    rst = 1'b0; bus.out_ready = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_y", 32'(bus.y), 32'd0);
    for (int k = 0; k < 4; k++) begin
      win(); #1;
      check("mid_rst_no_out", 32'(bus.out_valid), 32'd0);
    end
    check("mid_rst_pops", 32'(pops - p0), 32'd0);

    // Randomized traffic; a refused input is held until accepted
    hold = 1'b0;
    for (int k = 0; k < 400; k++) begin
      win();
      if (!hold) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.op = 3'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      hold = bus.in_valid && !bus.in_ready;
    end
    win();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0 && !bus.out_valid) break;
      win();
    end
    check("final_empty", 32'(exp_q.size()), 32'd0);
    check("final_balance", 32'(pushes), 32'(pops + dropped));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
